// File: rtl/dmem_responder.sv
// Data-memory responder for the processor load/store port.
// Captures one word request, waits a fixed number of cycles, then performs
// the access and pulses mem_ready for one cycle. Flags misaligned,
// out-of-range and simultaneous load/store requests.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no request in flight, waiting for readdmem|writedmem
// S_WAIT | request latched, wait counter running down to zero
// S_DONE | access completed this cycle, mem_ready/mem_err valid
// S_HOLD | completed, waiting for the request level to drop
//
// Completion lands WAIT_CYCLES+1 edges after the capture edge: the capture
// edge loads the counter, each WAIT edge counts down, and the edge seeing a
// zero count enters S_DONE. WAIT_CYCLES=0 therefore still spends one cycle
// in S_WAIT, giving ready one edge after capture.

module dmem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        readdmem,
    input  logic        writedmem,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        busy,
    output logic [15:0] access_count
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_HOLD
    } state_t;

    state_t               state;
    logic [3:0]           wait_cnt;
    logic [ADDR_BITS-1:0] idx_q;
    logic [31:0]          wdata_q;
    logic                 wr_q;
    logic                 err_q;

    logic [31:0]          mem [DEPTH];

    logic                 req;
    logic                 req_err;
    logic                 finish;
    logic                 commit_wr;

    assign req = readdmem | writedmem;

    // Both levels high is ambiguous, so it is rejected rather than prioritised.
    assign req_err = (readdmem & writedmem)
                   | (addr[1:0] != 2'b00)
                   | ((addr >> (ADDR_BITS + 2)) != 32'd0);

    assign finish    = (state == S_WAIT) && (wait_cnt == 4'd0);
    assign commit_wr = finish && !err_q && wr_q;

    assign busy = (state != S_IDLE);

    // Data array: no reset, a store commits on the same edge that enters S_DONE.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Request sequencing, completion outputs and access counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            wait_cnt     <= 4'd0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            readdata     <= 32'd0;
            mem_ready    <= 1'b0;
            mem_err      <= 1'b0;
            access_count <= 16'd0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        idx_q    <= addr[ADDR_BITS+1:2];
                        wdata_q  <= writedata;
                        wr_q     <= writedmem & ~readdmem;
                        err_q    <= req_err;
                        wait_cnt <= WAIT_INIT;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= S_DONE;
                        mem_ready <= 1'b1;
                        mem_err   <= err_q;
                        if (!err_q) begin
                            if (!wr_q) begin
                                readdata <= mem[idx_q];
                            end
                            access_count <= access_count + 16'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // A level still asserted here belongs to the finished access.
                    state <= req ? S_HOLD : S_IDLE;
                end
                S_HOLD: begin
                    if (!req) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// one with none, sharing a clock but with independent request ports.

module tb_dmem_responder;

    logic        clk;
    logic        a_reset, a_rd, a_wr;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_ready, a_err, a_busy;
    logic [15:0] a_cnt;
    logic        b_reset, b_rd, b_wr;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_ready, b_err, b_busy;
    logic [15:0] b_cnt;

    int          n_checks;
    int          n_pass;
    int          t_lat;
    logic [31:0] t_rdat;
    logic        t_err;

    dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(a_reset), .readdmem(a_rd), .writedmem(a_wr),
        .addr(a_addr), .writedata(a_wdata), .readdata(a_rdata),
        .mem_ready(a_ready), .mem_err(a_err), .busy(a_busy),
        .access_count(a_cnt)
    );

    dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(b_reset), .readdmem(b_rd), .writedmem(b_wr),
        .addr(b_addr), .writedata(b_wdata), .readdata(b_rdata),
        .mem_ready(b_ready), .mem_err(b_err), .busy(b_busy),
        .access_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel_b, input logic rd, input logic wr,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (sel_b) begin
            b_rd = rd; b_wr = wr; b_addr = ad; b_wdata = wd;
        end else begin
            a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = wd;
        end
    endtask

    // One request; optionally changes addr/data right after capture.
    task automatic xfer(input bit sel_b, input logic rd, input logic wr,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input bit chg, input logic [31:0] ad2, input logic [31:0] wd2);
        bit got;
        @(negedge clk);
        drive(sel_b, rd, wr, ad, wd);
        @(posedge clk); #1;
        if (chg) drive(sel_b, rd, wr, ad2, wd2);
        got   = 1'b0;
        t_lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            t_lat++;
            if (sel_b ? b_ready : a_ready) got = 1'b1;
        end
        if (!got) check("ready_timeout", 32'd0, 32'd1);
        t_rdat = sel_b ? b_rdata : a_rdata;
        t_err  = sel_b ? b_err : a_err;
        drive(sel_b, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic st(input bit sel_b, input logic [31:0] ad, input logic [31:0] wd);
        xfer(sel_b, 1'b0, 1'b1, ad, wd, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic ld(input bit sel_b, input logic [31:0] ad);
        xfer(sel_b, 1'b1, 1'b0, ad, 32'd0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        int pulses;
        int busy_low;
        n_checks = 0;
        n_pass   = 0;
        a_reset = 1'b1; b_reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        #2;
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_ready", {31'd0, a_ready}, 32'd0);
        check("rst_err", {31'd0, a_err}, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_cnt", {16'd0, a_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        a_reset = 1'b0; b_reset = 1'b0;

        st(1'b0, 32'h10, 32'hDEADBEEF);
        check("st10_lat", t_lat, 32'd3);
        check("st10_err", {31'd0, t_err}, 32'd0);
        ld(1'b0, 32'h10);
        check("ld10_lat", t_lat, 32'd3);
        check("ld10_data", t_rdat, 32'hDEADBEEF);
        check("ld10_err", {31'd0, t_err}, 32'd0);
        check("ld10_cnt", {16'd0, a_cnt}, 32'd2);

        ld(1'b0, 32'h12);
        check("mis_err", {31'd0, t_err}, 32'd1);
        check("mis_data", t_rdat, 32'hDEADBEEF);
        check("mis_cnt", {16'd0, a_cnt}, 32'd2);
        ld(1'b0, 32'h1000);
        check("oor_err", {31'd0, t_err}, 32'd1);
        check("oor_cnt", {16'd0, a_cnt}, 32'd2);

        st(1'b0, 32'h20, 32'h12345678);
        xfer(1'b0, 1'b1, 1'b1, 32'h20, 32'h00000BAD, 1'b0, 32'd0, 32'd0);
        check("both_err", {31'd0, t_err}, 32'd1);
        check("both_cnt", {16'd0, a_cnt}, 32'd3);
        ld(1'b0, 32'h20);
        check("both_keep", t_rdat, 32'h12345678);

        st(1'b0, 32'h04, 32'hCAFE0004);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h04, 32'd0);
        @(posedge clk); #1;
        pulses = 0;
        busy_low = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (a_ready) pulses++;
            if (!a_busy) busy_low++;
        end
        check("hold_pulses", pulses, 32'd1);
        check("hold_busy", busy_low, 32'd0);
        check("hold_data", a_rdata, 32'hCAFE0004);
        check("hold_cnt", {16'd0, a_cnt}, 32'd6);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check("hold_release", {31'd0, a_busy}, 32'd0);

        st(1'b0, 32'h0C, 32'h33333333);
        xfer(1'b0, 1'b0, 1'b1, 32'h08, 32'h11111111, 1'b1, 32'h0C, 32'h22222222);
        ld(1'b0, 32'h08);
        check("chg_08", t_rdat, 32'h11111111);
        ld(1'b0, 32'h0C);
        check("chg_0c", t_rdat, 32'h33333333);
        check("chg_cnt", {16'd0, a_cnt}, 32'd10);

        st(1'b0, 32'h30, 32'h00000000);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h30, 32'hA5A5A5A5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("mrst_rdata", a_rdata, 32'd0);
        check("mrst_cnt", {16'd0, a_cnt}, 32'd0);
        check("mrst_busy", {31'd0, a_busy}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (a_ready) pulses++;
        end
        @(negedge clk);
        a_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (a_ready) pulses++;
        end
        check("mrst_noready", pulses, 32'd0);
        ld(1'b0, 32'h30);
        check("mrst_data", t_rdat, 32'h00000000);
        check("mrst_cnt2", {16'd0, a_cnt}, 32'd1);

        st(1'b1, 32'h40, 32'h5A5A5A5A);
        check("w0_st_lat", t_lat, 32'd1);
        ld(1'b1, 32'h40);
        check("w0_ld_lat", t_lat, 32'd1);
        check("w0_ld_data", t_rdat, 32'h5A5A5A5A);
        check("w0_cnt", {16'd0, b_cnt}, 32'd2);
        @(negedge clk);
        force dut_b.access_count = 16'hFFFE;
        @(negedge clk);
        release dut_b.access_count;
        ld(1'b1, 32'h40);
        check("wrap_ffff", {16'd0, b_cnt}, 32'h0000FFFF);
        ld(1'b1, 32'h40);
        check("wrap_zero", {16'd0, b_cnt}, 32'h00000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
